// File: rtl/bakraid_snd_host.sv
// 68000-side sound mailbox: decodes the sound register window, drives the Z80
// command latches with CS/NMI strobes, stalls on WAIT and raises a sticky IRQ.
module bakraid_snd_host #(
   parameter int PULSE_W = 4,
   parameter int TIMEOUT = 4096,
   parameter int TW      = 13
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        SEL,
   input  logic        RNW,
   input  logic [2:0]  ADDR,
   input  logic [15:0] DIN,
   output logic [15:0] DOUT,
   output logic        DTACK_N,
   output logic [7:0]  SOUNDLATCH,
   output logic [7:0]  SOUNDLATCH2,
   output logic        CS,
   output logic        NMI,
   input  logic        WAIT,
   input  logic [7:0]  SOUNDLATCH3,
   input  logic [7:0]  SOUNDLATCH4,
   input  logic        SNDIRQ,
   output logic        IRQ
);

   localparam int PW = $clog2(PULSE_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STALL,
      ST_ACK
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            sel_q;
   logic            sel_qq;
   logic            sel_rise;
   logic            sndirq_q;
   logic            sndirq_rise;
   logic [TW-1:0]   stall_cnt;
   logic [PW-1:0]   cs_cnt;
   logic [PW-1:0]   nmi_cnt;
   logic            tmo;
   logic            cs_busy;
   logic            is_latch;
   logic            unused_din;

   logic            do_read;
   logic            do_commit;
   logic            do_force;
   logic            do_nmi;
   logic            do_status;
   logic            ack_set;
   logic            ack_clr;
   logic            stall_clr;
   logic            stall_inc;

   // sel_q is the bus-cycle view of SEL; the start edge is taken one stage later
   assign sel_rise    = sel_q & ~sel_qq;
   assign sndirq_rise = SNDIRQ & ~sndirq_q;
   assign cs_busy     = (cs_cnt != '0);
   assign is_latch    = ~RNW & (ADDR[2:1] == 2'b00);
   assign CS          = cs_busy;
   assign NMI         = (nmi_cnt != '0);
   assign unused_din  = ^DIN[15:8];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      do_read   = 1'b0;
      do_commit = 1'b0;
      do_force  = 1'b0;
      do_nmi    = 1'b0;
      do_status = 1'b0;
      ack_set   = 1'b0;
      ack_clr   = 1'b0;
      stall_clr = 1'b0;
      stall_inc = 1'b0;

      case (state)
         ST_IDLE: begin
            if (sel_rise) begin
               if (RNW) begin
                  do_read   = 1'b1;
                  ack_set   = 1'b1;
                  state_nxt = ST_ACK;
               end else if (is_latch) begin
                  if (!WAIT && !cs_busy) begin
                     do_commit = 1'b1;
                     state_nxt = ST_ACK;
                  end else begin
                     stall_clr = 1'b1;
                     state_nxt = ST_STALL;
                  end
               end else begin
                  do_nmi    = (ADDR == 3'd3);
                  do_status = (ADDR == 3'd4);
                  ack_set   = 1'b1;
                  state_nxt = ST_ACK;
               end
            end
         end

         ST_STALL: begin
            // a master that gives up mid-stall loses its write silently
            if (!sel_q) begin
               state_nxt = ST_IDLE;
            end else if (!WAIT && !cs_busy) begin
               do_commit = 1'b1;
               state_nxt = ST_ACK;
            end else if (stall_cnt == TW'(TIMEOUT - 1)) begin
               do_commit = 1'b1;
               do_force  = 1'b1;
               state_nxt = ST_ACK;
            end else begin
               stall_inc = 1'b1;
            end
         end

         ST_ACK: begin
            if (!sel_q) begin
               ack_clr   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sel_q       <= 1'b0;
         sel_qq      <= 1'b0;
         sndirq_q    <= 1'b0;
         stall_cnt   <= '0;
         cs_cnt      <= '0;
         nmi_cnt     <= '0;
         SOUNDLATCH  <= '0;
         SOUNDLATCH2 <= '0;
         DOUT        <= '0;
         DTACK_N     <= 1'b1;
         IRQ         <= 1'b0;
         tmo         <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every register samples pre-edge values.
         sel_q    <= SEL;
         sel_qq   <= sel_q;
         sndirq_q <= SNDIRQ;

         if (stall_clr) begin
            stall_cnt <= '0;
         end else if (stall_inc) begin
            stall_cnt <= stall_cnt + TW'(1);
         end

         if (do_commit) begin
            if (ADDR[0]) begin
               SOUNDLATCH2 <= DIN[7:0];
            end else begin
               SOUNDLATCH <= DIN[7:0];
            end
            cs_cnt <= PW'(PULSE_W);
         end else if (cs_busy) begin
            cs_cnt <= cs_cnt - PW'(1);
         end

         // a repeated NMI write only stretches the pulse, it never re-edges it
         if (do_nmi) begin
            nmi_cnt <= PW'(PULSE_W);
         end else if (NMI) begin
            nmi_cnt <= nmi_cnt - PW'(1);
         end

         if (do_read) begin
            case (ADDR)
               3'd2:    DOUT <= {SOUNDLATCH4, SOUNDLATCH3};
               3'd4:    DOUT <= {13'b0, tmo, IRQ, WAIT};
               default: DOUT <= 16'hFFFF;
            endcase
         end

         if (ack_set || do_commit) begin
            DTACK_N <= 1'b0;
         end else if (ack_clr) begin
            DTACK_N <= 1'b1;
         end

         if (sndirq_rise) begin
            IRQ <= 1'b1;
         end else if (do_status && DIN[1]) begin
            IRQ <= 1'b0;
         end

         if (do_force) begin
            tmo <= 1'b1;
         end else if (do_status && DIN[2]) begin
            tmo <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bakraid_snd_host.sv
// Bench for bakraid_snd_host: two instances (long and short timeout) checked every
// cycle against a bus-phase model, plus hand-computed literal expectations.
module tb_bakraid_snd_host;

   localparam int PULSE_W = 4;
   localparam int TO_L    = 128;
   localparam int TO_S    = 16;

   typedef struct {
      bit        seen;
      bit        seen_prev;
      int        phase;       // 0 idle, 1 waiting on sound board, 2 acknowledging
      int        waited;
      int        cs_left;
      int        nmi_left;
      bit [7:0]  lat1;
      bit [7:0]  lat2;
      bit [15:0] dout;
      bit        dtack_n;
      bit        irq;
      bit        tmo;
      bit        sndirq_prev;
   } mdl_t;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        SEL;
   logic        RNW;
   logic [2:0]  ADDR;
   logic [15:0] DIN;
   logic        WAIT;
   logic [7:0]  SL3;
   logic [7:0]  SL4;
   logic        SNDIRQ;

   logic [15:0] l_dout, s_dout;
   logic        l_dtack_n, s_dtack_n;
   logic [7:0]  l_sl1, s_sl1, l_sl2, s_sl2;
   logic        l_cs, s_cs, l_nmi, s_nmi, l_irq, s_irq;

   int   vec_cnt = 0;
   int   err_cnt = 0;
   bit   chk_en  = 1'b0;
   mdl_t ml;
   mdl_t ms;

   bakraid_snd_host #(.PULSE_W(PULSE_W), .TIMEOUT(TO_L), .TW(8)) u_long (
      .CLK(CLK), .RESET(RESET), .SEL(SEL), .RNW(RNW), .ADDR(ADDR), .DIN(DIN),
      .DOUT(l_dout), .DTACK_N(l_dtack_n), .SOUNDLATCH(l_sl1), .SOUNDLATCH2(l_sl2),
      .CS(l_cs), .NMI(l_nmi), .WAIT(WAIT), .SOUNDLATCH3(SL3), .SOUNDLATCH4(SL4),
      .SNDIRQ(SNDIRQ), .IRQ(l_irq)
   );

   bakraid_snd_host #(.PULSE_W(PULSE_W), .TIMEOUT(TO_S), .TW(5)) u_short (
      .CLK(CLK), .RESET(RESET), .SEL(SEL), .RNW(RNW), .ADDR(ADDR), .DIN(DIN),
      .DOUT(s_dout), .DTACK_N(s_dtack_n), .SOUNDLATCH(s_sl1), .SOUNDLATCH2(s_sl2),
      .CS(s_cs), .NMI(s_nmi), .WAIT(WAIT), .SOUNDLATCH3(SL3), .SOUNDLATCH4(SL4),
      .SNDIRQ(SNDIRQ), .IRQ(s_irq)
   );

   always #5 CLK = ~CLK;

   function automatic mdl_t step(input mdl_t m, input logic rst, input logic sel,
                                 input logic rnw, input logic [2:0] addr,
                                 input logic [15:0] din, input logic wt,
                                 input logic [7:0] l3, input logic [7:0] l4,
                                 input logic irq_in, input int timeout);
      mdl_t n;
      bit   commit;
      bit   clr_irq;
      n = m;
      if (rst) begin
         n.seen = 0; n.seen_prev = 0; n.phase = 0; n.waited = 0;
         n.cs_left = 0; n.nmi_left = 0; n.lat1 = 0; n.lat2 = 0; n.dout = 0;
         n.dtack_n = 1; n.irq = 0; n.tmo = 0; n.sndirq_prev = 0;
         return n;
      end
      commit  = 0;
      clr_irq = 0;
      n.seen        = sel;
      n.seen_prev   = m.seen;
      n.sndirq_prev = irq_in;
      n.cs_left     = (m.cs_left > 0) ? m.cs_left - 1 : 0;
      n.nmi_left    = (m.nmi_left > 0) ? m.nmi_left - 1 : 0;
      case (m.phase)
         0: if (m.seen && !m.seen_prev) begin
            if (rnw) begin
               n.dout = (addr == 3'd2) ? {l4, l3} :
                        (addr == 3'd4) ? {13'd0, m.tmo, m.irq, wt} : 16'hFFFF;
               n.dtack_n = 0;
               n.phase   = 2;
            end else if (addr < 3'd2) begin
               if (!wt && m.cs_left == 0) commit = 1;
               else begin n.phase = 1; n.waited = 0; end
            end else begin
               if (addr == 3'd3) n.nmi_left = PULSE_W;
               if (addr == 3'd4) begin
                  clr_irq = din[1];
                  if (din[2]) n.tmo = 0;
               end
               n.dtack_n = 0;
               n.phase   = 2;
            end
         end
         1: begin
            if (!m.seen) n.phase = 0;
            else if (!wt && m.cs_left == 0) commit = 1;
            else if (m.waited == timeout - 1) begin commit = 1; n.tmo = 1; end
            else n.waited = m.waited + 1;
         end
         default: if (!m.seen) begin n.dtack_n = 1; n.phase = 0; end
      endcase
      if (commit) begin
         if (addr[0]) n.lat2 = din[7:0];
         else n.lat1 = din[7:0];
         n.cs_left = PULSE_W;
         n.dtack_n = 0;
         n.phase   = 2;
      end
      if (irq_in && !m.sndirq_prev) n.irq = 1;
      else if (clr_irq) n.irq = 0;
      return n;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input string tag, input mdl_t m, input logic [15:0] dout,
                      input logic dtack_n, input logic [7:0] sl1, input logic [7:0] sl2,
                      input logic cs, input logic nmi, input logic irq);
      check({tag, ".dout"}, dout, m.dout);
      check({tag, ".dtack_n"}, {15'd0, dtack_n}, {15'd0, m.dtack_n});
      check({tag, ".soundlatch"}, {8'd0, sl1}, {8'd0, m.lat1});
      check({tag, ".soundlatch2"}, {8'd0, sl2}, {8'd0, m.lat2});
      check({tag, ".cs"}, {15'd0, cs}, {15'd0, m.cs_left > 0});
      check({tag, ".nmi"}, {15'd0, nmi}, {15'd0, m.nmi_left > 0});
      check({tag, ".irq"}, {15'd0, irq}, {15'd0, m.irq});
   endtask

   always @(posedge CLK) begin
      ml <= step(ml, RESET, SEL, RNW, ADDR, DIN, WAIT, SL3, SL4, SNDIRQ, TO_L);
      ms <= step(ms, RESET, SEL, RNW, ADDR, DIN, WAIT, SL3, SL4, SNDIRQ, TO_S);
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         cmp("long", ml, l_dout, l_dtack_n, l_sl1, l_sl2, l_cs, l_nmi, l_irq);
         cmp("short", ms, s_dout, s_dtack_n, s_sl1, s_sl2, s_cs, s_nmi, s_irq);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic drive(input logic s, input logic rnw, input logic [2:0] a, input logic [15:0] d);
      SEL = s; RNW = rnw; ADDR = a; DIN = d;
   endtask

   initial begin
      RESET = 1'b1; SEL = 1'b0; RNW = 1'b1; ADDR = 3'd0; DIN = 16'd0;
      WAIT = 1'b0; SL3 = 8'd0; SL4 = 8'd0; SNDIRQ = 1'b0;
      tick(3);
      chk_en = 1'b1;
      check("rst dtack_n", {15'd0, l_dtack_n}, 16'd1);
      check("rst dout", l_dout, 16'h0000);
      check("rst latch", {l_sl1, l_sl2}, 16'h0000);
      check("rst cs/nmi/irq", {13'd0, s_cs, s_nmi, s_irq}, 16'h0000);
      RESET = 1'b0;
      tick(2);

      // unstalled write to latch 1
      drive(1, 0, 3'd0, 16'h00A5);
      tick(1);
      check("t1 n+1 cs", {15'd0, l_cs}, 16'd0);
      check("t1 n+1 dtack_n", {15'd0, l_dtack_n}, 16'd1);
      tick(1);
      check("t1 latch", {8'd0, l_sl1}, 16'h00A5);
      check("t1 cs rise", {15'd0, l_cs}, 16'd1);
      check("t1 dtack", {15'd0, l_dtack_n}, 16'd0);
      tick(3);
      check("t1 cs last", {15'd0, l_cs}, 16'd1);
      tick(1);
      check("t1 cs end", {15'd0, l_cs}, 16'd0);
      check("t1 dtack held", {15'd0, l_dtack_n}, 16'd0);
      SEL = 1'b0;
      tick(1);
      check("t1 dtack after drop", {15'd0, l_dtack_n}, 16'd0);
      tick(1);
      check("t1 dtack release", {15'd0, l_dtack_n}, 16'd1);
      tick(3);

      // second latch write arrives while CS is still high
      drive(1, 0, 3'd0, 16'h0001);
      tick(2);
      check("bb first latch", {8'd0, l_sl1}, 16'h0001);
      SEL = 1'b0;
      tick(1);
      drive(1, 0, 3'd1, 16'h0055);
      tick(3);
      check("bb cs gap", {15'd0, l_cs}, 16'd0);
      check("bb latch2 held", {8'd0, l_sl2}, 16'h0000);
      tick(1);
      check("bb cs again", {15'd0, l_cs}, 16'd1);
      check("bb latch2", {8'd0, l_sl2}, 16'h0055);
      SEL = 1'b0;
      tick(4);

      // WAIT stall for 100 cycles
      WAIT = 1'b1;
      drive(1, 0, 3'd1, 16'h0033);
      for (int i = 1; i <= 100; i++) begin
         tick(1);
         check("t2 stall dtack", {15'd0, l_dtack_n}, 16'd1);
         if (i == 18) begin
            check("t2 short forced dtack", {15'd0, s_dtack_n}, 16'd0);
            check("t2 short forced latch2", {8'd0, s_sl2}, 16'h0033);
         end
      end
      check("t2 latch2 before", {8'd0, l_sl2}, 16'h0055);
      check("t2 cs before", {15'd0, l_cs}, 16'd0);
      WAIT = 1'b0;
      tick(1);
      check("t2 latch2", {8'd0, l_sl2}, 16'h0033);
      check("t2 cs", {15'd0, l_cs}, 16'd1);
      check("t2 dtack", {15'd0, l_dtack_n}, 16'd0);
      SEL = 1'b0;
      tick(4);

      // clear tmo and confirm through a status read
      drive(1, 0, 3'd4, 16'h0004);
      tick(3);
      SEL = 1'b0;
      tick(4);
      drive(1, 1, 3'd4, 16'h0000);
      tick(2);
      check("tmo cleared", s_dout, 16'h0000);
      SEL = 1'b0;
      tick(4);

      // permanent WAIT forces commits after the timeout
      WAIT = 1'b1;
      drive(1, 0, 3'd0, 16'h0011);
      for (int i = 1; i <= 131; i++) begin
         tick(1);
         if (i == 17) check("t3 short pre-timeout", {15'd0, s_dtack_n}, 16'd1);
         if (i == 18) begin
            check("t3 short forced dtack", {15'd0, s_dtack_n}, 16'd0);
            check("t3 short forced latch", {8'd0, s_sl1}, 16'h0011);
            check("t3 short forced cs", {15'd0, s_cs}, 16'd1);
         end
         if (i == 129) check("t3 long pre-timeout", {15'd0, l_dtack_n}, 16'd1);
         if (i == 130) begin
            check("t3 long forced dtack", {15'd0, l_dtack_n}, 16'd0);
            check("t3 long forced latch", {8'd0, l_sl1}, 16'h0011);
         end
      end
      SEL = 1'b0;
      tick(4);
      drive(1, 1, 3'd4, 16'h0000);
      tick(2);
      check("t3 status long", l_dout, 16'h0005);
      check("t3 status short", s_dout, 16'h0005);
      SEL = 1'b0;
      tick(4);

      // SNDIRQ edge on the same cycle as an IRQ clear: set wins
      WAIT = 1'b0;
      drive(1, 0, 3'd4, 16'h0002);
      tick(1);
      check("t4 irq idle", {15'd0, l_irq}, 16'd0);
      SNDIRQ = 1'b1;
      tick(1);
      check("t4 irq set wins long", {15'd0, l_irq}, 16'd1);
      check("t4 irq set wins short", {15'd0, s_irq}, 16'd1);
      SNDIRQ = 1'b0;
      SEL = 1'b0;
      tick(4);
      drive(1, 0, 3'd4, 16'h0002);
      tick(2);
      check("t4 irq cleared", {15'd0, l_irq}, 16'd0);
      SEL = 1'b0;
      tick(4);

      // NMI rewrite while high stretches the pulse
      drive(1, 0, 3'd3, 16'hFFFF);
      tick(2);
      check("nmi rise", {15'd0, l_nmi}, 16'd1);
      SEL = 1'b0;
      tick(1);
      SEL = 1'b1;
      tick(5);
      check("nmi stretched", {15'd0, l_nmi}, 16'd1);
      tick(1);
      check("nmi end", {15'd0, l_nmi}, 16'd0);
      SEL = 1'b0;
      tick(4);

      // reply latches and unmapped read
      SL3 = 8'h12;
      SL4 = 8'h34;
      drive(1, 1, 3'd2, 16'h0000);
      tick(2);
      check("t5 reply read", l_dout, 16'h3412);
      SEL = 1'b0;
      tick(4);
      drive(1, 1, 3'd7, 16'h0000);
      tick(2);
      check("t5 unmapped read", l_dout, 16'hFFFF);
      SEL = 1'b0;
      tick(4);

      // reset while stalled
      WAIT = 1'b1;
      drive(1, 0, 3'd0, 16'h0077);
      tick(5);
      check("t6 stalled", {15'd0, l_dtack_n}, 16'd1);
      RESET = 1'b1;
      SEL = 1'b0;
      tick(1);
      check("t6 dtack_n", {15'd0, l_dtack_n}, 16'd1);
      check("t6 cs", {15'd0, l_cs}, 16'd0);
      check("t6 latches", {l_sl1, l_sl2}, 16'h0000);
      RESET = 1'b0;
      WAIT = 1'b0;
      tick(2);
      drive(1, 1, 3'd2, 16'h0000);
      tick(2);
      check("t6 idle read", l_dout, 16'h3412);
      check("t6 idle dtack", {15'd0, l_dtack_n}, 16'd0);
      check("t6 write lost", {8'd0, l_sl1}, 16'h0000);
      SEL = 1'b0;
      tick(4);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/bakraid_snd_host.md
# bakraid_snd_host

Main-CPU (68000) side of the sound mailbox. It decodes 68k accesses to the sound register window and drives the command latches, the CS strobe and the NMI strobe consumed by the Z80 sound block. It stalls 68k latch writes while that block reports WAIT, returns the Z80 reply latches, and turns the Z80 SNDIRQ strobe into a sticky interrupt for the 68k.

## Interface
Parameters:
- PULSE_W, 4: length of CS and NMI strobes in CLK cycles (≥2).
- TIMEOUT, 4096: maximum stall cycles before a forced commit.
- TW, 13: width of the stall counter (must hold TIMEOUT).

Ports:
- CLK  in  1  system clock, the only clock.
- RESET  in  1  synchronous, active-high reset.
- SEL  in  1  68k chip select for the window; level, high for the whole bus cycle.
- RNW  in  1  1 = read, 0 = write; valid while SEL.
- ADDR  in  3  68k A[3:1] word offset.
- DIN  in  16  68k write data.
- DOUT  out  16  read data, registered.
- DTACK_N  out  1  active-low acknowledge.
- SOUNDLATCH  out  8  command latch 1 to the Z80.
- SOUNDLATCH2  out  8  command latch 2 to the Z80.
- CS  out  1  strobe; its rising edge sets WAIT in the sound block.
- NMI  out  1  strobe; its rising edge raises the Z80 NMI.
- WAIT  in  1  sound block busy; high until the Z80 writes reply latch 3 or 4.
- SOUNDLATCH3  in  8  Z80 reply latch 3.
- SOUNDLATCH4  in  8  Z80 reply latch 4.
- SNDIRQ  in  1  Z80 interrupt request; edge-detected.
- IRQ  out  1  sticky interrupt to the 68k.

## Operation
Register map (ADDR):
- 0 W: write DIN[7:0] into SOUNDLATCH, then strobe CS.
- 1 W: write DIN[7:0] into SOUNDLATCH2, then strobe CS.
- 2 R: returns {SOUNDLATCH4, SOUNDLATCH3}.
- 3 W: strobe NMI; data is ignored.
- 4 R: returns {13'b0, tmo, IRQ, WAIT}.
- 4 W: DIN[1]=1 clears IRQ; DIN[2]=1 clears tmo.
- Any other read returns 16'hFFFF. Any other write is acknowledged with no effect.

Cycle start:
- A cycle starts on a SEL rising edge, detected against a registered copy of SEL.
- A cycle starts only in IDLE.

FSM states: IDLE, STALL, ACK.
- IDLE, read: load DOUT, drive DTACK_N=0, go to ACK.
- IDLE, latch write (ADDR 0/1), WAIT=0 and CS strobe counter idle: commit, go to ACK.
- IDLE, latch write, WAIT=1 or CS strobe still active: go to STALL, clear the stall counter.
- IDLE, any other write: perform its action, go to ACK.
- STALL: the counter increments each cycle. Commit and go to ACK when WAIT=0 and the CS strobe has ended. If the counter reaches TIMEOUT-1 first, set tmo, commit anyway and go to ACK.
- ACK: hold DTACK_N=0 while SEL=1. When SEL=0, DTACK_N=1 and go to IDLE.
- SEL dropping during STALL: abandon the write (no commit, no DTACK) and go to IDLE.

Commit:
- Latch register <= DIN[7:0].
- CS <= 1 and load the CS strobe counter with PULSE_W.

Strobes:
- CS and NMI each have their own down-counter and stay high for exactly PULSE_W cycles.
- Strobes run independently of SEL.
- An NMI write while NMI is already high reloads the counter; no new edge is generated.

IRQ:
- An SNDIRQ rising edge sets IRQ.
- A status write with DIN[1]=1 clears IRQ.
- Set and clear in the same cycle: set wins.

## Timing
- Reset values: DOUT=0, DTACK_N=1, SOUNDLATCH=0, SOUNDLATCH2=0, CS=0, NMI=0, IRQ=0, tmo=0, FSM=IDLE, all counters 0.
- SEL rises in cycle N; the edge is seen in N+1.
- Read: DOUT valid and DTACK_N=0 at N+2.
- Unstalled write: latch value, CS=1 and DTACK_N=0 at N+2. CS stays high through N+1+PULSE_W.
- Stalled write: commit condition true in cycle M gives latch value, CS and DTACK_N=0 at M+1.
- Forced commit: at most TIMEOUT+2 cycles after the edge.
- DTACK_N returns high in the cycle after SEL is sampled low.
- SNDIRQ edge sampled in cycle K gives IRQ=1 at K+1.
- RESET mid-cycle: all state returns to reset values on the next edge. A strobe in progress is truncated. A latch write not yet committed is lost.

## Test plan
- After reset: write ADDR0 = 16'h00A5 with WAIT=0. Expect SOUNDLATCH=8'hA5 and CS high for 4 cycles at N+2, DTACK_N low until SEL drops.
- Hold WAIT=1, write ADDR1 = 16'h0033, drop WAIT after 100 cycles. Expect DTACK_N to stay high during the stall, and SOUNDLATCH2=8'h33 with CS rising in the cycle after WAIT falls.
- Hold WAIT=1 permanently, write ADDR0 = 16'h0011 with TIMEOUT=16. Expect a forced commit with DTACK_N low at N+18, then a status read returning 16'h0005.
- Pulse SNDIRQ and, in the same cycle, write status DIN=16'h0002. Expect IRQ=1. A second clear write with SNDIRQ idle gives IRQ=0.
- Drive SOUNDLATCH3=8'h12 and SOUNDLATCH4=8'h34, read ADDR2. Expect DOUT=16'h3412. Read ADDR7, expect 16'hFFFF.
- Assert RESET during STALL. Expect DTACK_N=1, CS=0, latches 0 and FSM in IDLE on the next cycle.
